// File: rtl/logic_gate_nway_reg.sv
// Registered N-way bitwise gate (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS) behind a one-entry valid/ready stage.
// Optional REDUCE_OUT_EN adds registered y_any/y_all reductions of the result.

module logic_gate_nway_lane #(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0] i_bits,
   input  logic [2:0]      i_op,
   output logic            o_bit
);
   always_comb begin
      o_bit = i_bits[0];
      case (i_op)
         3'd0:    o_bit =  (&i_bits);
         3'd1:    o_bit =  (|i_bits);
         3'd2:    o_bit =  (^i_bits);
         3'd3:    o_bit = ~(&i_bits);
         3'd4:    o_bit = ~(|i_bits);
         3'd5:    o_bit = ~(^i_bits);
         3'd6:    o_bit = ~i_bits[0];
         default: o_bit =  i_bits[0];
      endcase
   end
endmodule

module logic_gate_nway_reg #(
   parameter int WIDTH = 8,
   parameter int N_IN  = 2,
   parameter int CNT_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [2:0]            i_op,
   input  logic [WIDTH*N_IN-1:0] i_a,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [WIDTH-1:0]      o_y,
   output logic [2:0]            o_y_op,
   output logic [CNT_W-1:0]      o_acc_cnt
`ifdef REDUCE_OUT_EN
   ,
   output logic                  o_y_any,
   output logic                  o_y_all
`endif
);
   logic [N_IN-1:0][WIDTH-1:0] w_opnd;
   logic [WIDTH-1:0][N_IN-1:0] w_lane_bits;
   logic [WIDTH-1:0]           w_res;
   logic                       w_accept;

   logic                       r_out_valid;
   logic [WIDTH-1:0]           r_y;
   logic [2:0]                 r_y_op;
   logic [CNT_W-1:0]           r_acc_cnt;

   assign w_opnd     = i_a;
   assign o_in_ready = !r_out_valid || i_out_ready;
   assign w_accept   = i_in_valid && o_in_ready;

   // Transpose operands so each lane sees bit b of every operand.
   for (genvar b = 0; b < WIDTH; b++) begin : g_lane
      for (genvar k = 0; k < N_IN; k++) begin : g_bit
         assign w_lane_bits[b][k] = w_opnd[k][b];
      end
      logic_gate_nway_lane #(.N_IN(N_IN)) u_lane (
         .i_bits (w_lane_bits[b]),
         .i_op   (i_op),
         .o_bit  (w_res[b])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_y_op      <= '0;
         r_acc_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_res;
            r_y_op      <= i_op;
            r_acc_cnt   <= r_acc_cnt + CNT_W'(1);
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_y         = r_y;
   assign o_y_op      = r_y_op;
   assign o_acc_cnt   = r_acc_cnt;

`ifdef REDUCE_OUT_EN
   logic r_y_any, r_y_all;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_y_any <= 1'b0;
         r_y_all <= 1'b0;
      end else if (w_accept) begin
         r_y_any <= |w_res;
         r_y_all <= &w_res;
      end
   end

   assign o_y_any = r_y_any;
   assign o_y_all = r_y_all;
`endif

endmodule

// File: tb/tb_logic_gate_nway_reg.sv
// Bench for logic_gate_nway_reg: three parameterisations, table sweeps with scoreboards, and hand sequences
// for backpressure, counter wrap and asynchronous reset. Builds with or without REDUCE_OUT_EN.

module tb_logic_gate_nway_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   typedef struct { logic [7:0] y; logic [2:0] op; } sb_t;

   // d0: WIDTH=8, N_IN=2, CNT_W=4
   logic d0_iv = 0, d0_ir, d0_ov, d0_ordy = 0;
   logic [2:0] d0_op = 0, d0_yop;
   logic [15:0] d0_a = 0;
   logic [7:0] d0_y;
   logic [3:0] d0_cnt;
`ifdef REDUCE_OUT_EN
   logic d0_any, d0_all;
`endif

   logic_gate_nway_reg #(.WIDTH(8), .N_IN(2), .CNT_W(4)) u_d0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(d0_iv), .o_in_ready(d0_ir), .i_op(d0_op), .i_a(d0_a),
      .o_out_valid(d0_ov), .i_out_ready(d0_ordy), .o_y(d0_y), .o_y_op(d0_yop), .o_acc_cnt(d0_cnt)
`ifdef REDUCE_OUT_EN
      , .o_y_any(d0_any), .o_y_all(d0_all)
`endif
   );

   // d1: WIDTH=8, N_IN=3
   logic d1_iv = 0, d1_ir, d1_ov, d1_ordy = 1;
   logic [2:0] d1_op = 0, d1_yop;
   logic [23:0] d1_a = 0;
   logic [7:0] d1_y;
   logic [15:0] d1_cnt;
`ifdef REDUCE_OUT_EN
   logic d1_any, d1_all;
`endif

   logic_gate_nway_reg #(.WIDTH(8), .N_IN(3), .CNT_W(16)) u_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(d1_iv), .o_in_ready(d1_ir), .i_op(d1_op), .i_a(d1_a),
      .o_out_valid(d1_ov), .i_out_ready(d1_ordy), .o_y(d1_y), .o_y_op(d1_yop), .o_acc_cnt(d1_cnt)
`ifdef REDUCE_OUT_EN
      , .o_y_any(d1_any), .o_y_all(d1_all)
`endif
   );

   // d2: WIDTH=1, N_IN=2 truth sweep
   logic d2_iv = 0, d2_ir, d2_ov, d2_ordy = 1;
   logic [2:0] d2_op = 0, d2_yop;
   logic [1:0] d2_a = 0;
   logic d2_y;
   logic [15:0] d2_cnt;
`ifdef REDUCE_OUT_EN
   logic d2_any, d2_all;
`endif

   logic_gate_nway_reg #(.WIDTH(1), .N_IN(2), .CNT_W(16)) u_d2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(d2_iv), .o_in_ready(d2_ir), .i_op(d2_op), .i_a(d2_a),
      .o_out_valid(d2_ov), .i_out_ready(d2_ordy), .o_y(d2_y), .o_y_op(d2_yop), .o_acc_cnt(d2_cnt)
`ifdef REDUCE_OUT_EN
      , .o_y_any(d2_any), .o_y_all(d2_all)
`endif
   );

   sb_t q1[$];
   sb_t q2[$];

   always @(negedge clk) begin
      if (rst_n && d1_ov && d1_ordy) begin
         if (q1.size() == 0) chk("d1 unexpected deliver", 1, 0);
         else begin
            sb_t e;
            e = q1.pop_front();
            chk("d1 y", {24'h0, d1_y}, {24'h0, e.y});
            chk("d1 y_op", {29'h0, d1_yop}, {29'h0, e.op});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && d2_ov && d2_ordy) begin
         if (q2.size() == 0) chk("d2 unexpected deliver", 1, 0);
         else begin
            sb_t e;
            e = q2.pop_front();
            chk("d2 y", {31'h0, d2_y}, {24'h0, e.y});
            chk("d2 y_op", {29'h0, d2_yop}, {29'h0, e.op});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct { logic [2:0] op; logic [1:0] a; logic y; } v2_t;
   typedef struct { logic [2:0] op; logic [23:0] a; logic [7:0] y; } v1_t;

   v2_t vec2[32];
   v1_t vec1[11];
   logic [3:0] truth[8];

   initial begin
      // bit v of each entry is y for a = v (a[0] = operand 0)
      truth[0] = 4'b1000; truth[1] = 4'b1110; truth[2] = 4'b0110; truth[3] = 4'b0111;
      truth[4] = 4'b0001; truth[5] = 4'b1001; truth[6] = 4'b0101; truth[7] = 4'b1010;
      for (int o = 0; o < 8; o++)
         for (int v = 0; v < 4; v++) begin
            logic [3:0] t;
            t = truth[o];
            vec2[o*4+v] = '{3'(o), 2'(v), t[v]};
         end
      vec1[0]  = '{3'd2, 24'hFF0F01, 8'hF1};
      vec1[1]  = '{3'd5, 24'hFF0F01, 8'h0E};
      vec1[2]  = '{3'd3, 24'hFF0F01, 8'hFE};
      vec1[3]  = '{3'd4, 24'hFF0F01, 8'h00};
      vec1[4]  = '{3'd0, 24'hFF0F01, 8'h01};
      vec1[5]  = '{3'd1, 24'hFF0F01, 8'hFF};
      vec1[6]  = '{3'd2, 24'hAACCF0, 8'h96};
      vec1[7]  = '{3'd0, 24'hAACCF0, 8'h80};
      vec1[8]  = '{3'd1, 24'hAACCF0, 8'hFE};
      vec1[9]  = '{3'd6, 24'hAACCF0, 8'h0F};
      vec1[10] = '{3'd7, 24'hAACCF0, 8'hF0};

      #2;
      chk("reset out_valid", {31'h0, d0_ov}, 0);
      chk("reset y", {24'h0, d0_y}, 0);
      chk("reset y_op", {29'h0, d0_yop}, 0);
      chk("reset acc_cnt", {28'h0, d0_cnt}, 0);
`ifdef REDUCE_OUT_EN
      chk("reset y_any", {31'h0, d0_any}, 0);
      chk("reset y_all", {31'h0, d0_all}, 0);
`endif
      #10 rst_n = 1'b1;
      #1 chk("in_ready after release", {31'h0, d0_ir}, 1);

      // d2 truth sweep, back-to-back
      tick();
      for (int i = 0; i < 32; i++) begin
         d2_op = vec2[i].op; d2_a = vec2[i].a; d2_iv = 1'b1;
         #1;
         if (d2_ir) q2.push_back('{{7'h0, vec2[i].y}, vec2[i].op});
         else chk("d2 in_ready", 0, 1);
         @(posedge clk); #1;
         chk("d2 latency out_valid", {31'h0, d2_ov}, 1);
      end
      d2_iv = 1'b0;
      tick(); tick();
      chk("d2 scoreboard drained", q2.size(), 0);
      chk("d2 acc_cnt", {16'h0, d2_cnt}, 32);

      // d1 N_IN=3 table with random backpressure
      for (int i = 0; i < 11; i++) begin
         bit done;
         done = 0;
         d1_op = vec1[i].op; d1_a = vec1[i].a; d1_iv = 1'b1;
         for (int w = 0; w < 50 && !done; w++) begin
            d1_ordy = 1'($urandom_range(0, 1));
            #1;
            if (d1_ir) begin
               q1.push_back('{vec1[i].y, vec1[i].op});
               done = 1;
            end
            @(posedge clk); #1;
         end
         if (!done) chk("d1 accept timeout", 0, 1);
      end
      d1_iv = 1'b0; d1_ordy = 1'b1;
      tick(); tick();
      chk("d1 scoreboard drained", q1.size(), 0);
      chk("d1 acc_cnt", {16'h0, d1_cnt}, 11);

      // d0 OR after reset
      d0_op = 3'd1; d0_a = {8'h0F, 8'hF0}; d0_iv = 1'b1; d0_ordy = 1'b1;
      tick();
      d0_iv = 1'b0;
      chk("OR y", {24'h0, d0_y}, 32'hFF);
      chk("OR out_valid", {31'h0, d0_ov}, 1);
      chk("OR y_op", {29'h0, d0_yop}, 1);
      chk("OR acc_cnt", {28'h0, d0_cnt}, 1);
`ifdef REDUCE_OUT_EN
      chk("FF y_any", {31'h0, d0_any}, 1);
      chk("FF y_all", {31'h0, d0_all}, 1);
`endif
      tick();
      chk("deliver out_valid", {31'h0, d0_ov}, 0);
      chk("deliver y hold", {24'h0, d0_y}, 32'hFF);

      // backpressure
      d0_op = 3'd0; d0_a = {8'h3C, 8'hFF}; d0_iv = 1'b1; d0_ordy = 1'b0;
      tick();
      d0_op = 3'd2; d0_a = {8'h01, 8'h02};
      #1 chk("stall in_ready", {31'h0, d0_ir}, 0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stall y", {24'h0, d0_y}, 32'h3C);
         chk("stall y_op", {29'h0, d0_yop}, 0);
         chk("stall out_valid", {31'h0, d0_ov}, 1);
         chk("stall acc_cnt", {28'h0, d0_cnt}, 2);
      end
      d0_ordy = 1'b1;
      #1 chk("release in_ready", {31'h0, d0_ir}, 1);
      tick();
      chk("no-bubble y", {24'h0, d0_y}, 32'h03);
      chk("no-bubble y_op", {29'h0, d0_yop}, 2);
      chk("no-bubble out_valid", {31'h0, d0_ov}, 1);
      chk("no-bubble acc_cnt", {28'h0, d0_cnt}, 3);
      d0_op = 3'd7; d0_a = 16'h0000;
      tick();
      d0_iv = 1'b0;
      chk("PASS 00 y", {24'h0, d0_y}, 0);
`ifdef REDUCE_OUT_EN
      chk("00 y_any", {31'h0, d0_any}, 0);
      chk("00 y_all", {31'h0, d0_all}, 0);
`endif
      tick();
      chk("idle out_valid", {31'h0, d0_ov}, 0);

      // counter wrap at CNT_W=4
      #2 rst_n = 1'b0;
      #1 chk("pulse acc_cnt", {28'h0, d0_cnt}, 0);
      rst_n = 1'b1;
      tick();
      d0_op = 3'd1; d0_a = 16'h1234; d0_iv = 1'b1; d0_ordy = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("wrap acc_cnt", {28'h0, d0_cnt}, k % 16);
      end
      d0_iv = 1'b0;
      tick();

      // async reset mid-stall
      d0_op = 3'd7; d0_a = {8'h00, 8'hA5}; d0_iv = 1'b1; d0_ordy = 1'b0;
      tick();
      d0_iv = 1'b0;
      chk("pre-reset y", {24'h0, d0_y}, 32'hA5);
      tick(); tick();
      #3 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", {31'h0, d0_ov}, 0);
      chk("async rst y", {24'h0, d0_y}, 0);
      chk("async rst y_op", {29'h0, d0_yop}, 0);
      chk("async rst acc_cnt", {28'h0, d0_cnt}, 0);
      chk("async rst in_ready", {31'h0, d0_ir}, 1);
      #2 rst_n = 1'b1;
      tick();
      chk("post rst out_valid", {31'h0, d0_ov}, 0);
      chk("post rst in_ready", {31'h0, d0_ir}, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
